// File: rtl/bp_fpga_host_io_exerciser_pkg.sv
// Purpose: shared types and constants for the FPGA host I/O exerciser.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
// Contents: generator state enum, a compact I/O message layout (header + 64b data),
// message type / size encodings, default putchar address and a size-mask helper.
package bp_fpga_host_exerciser_pkg;

    localparam int paddr_width_gp = 40;
    localparam int data_width_gp  = 64;

    typedef enum logic [1:0] {
        e_ready = 2'd0,
        e_send  = 2'd1,
        e_drain = 2'd2
    } bp_fpga_host_exerciser_state_e;

    // Message type / subop / size encodings used on the I/O links
    localparam logic [3:0] msg_uc_rd_gp     = 4'd0;
    localparam logic [3:0] msg_uc_wr_gp     = 4'd1;
    localparam logic [3:0] subop_store_gp   = 4'd0;

    localparam logic [paddr_width_gp-1:0] default_putchar_addr_gp = 40'h00_0010_1000;

    typedef struct packed {
        logic [3:0]                msg_type;
        logic [3:0]                subop;
        logic [paddr_width_gp-1:0] addr;
        logic [2:0]                size;     // log2 of bytes
    } bp_io_hdr_s;

    typedef struct packed {
        bp_io_hdr_s               hdr;
        logic [data_width_gp-1:0] data;
    } bp_io_msg_s;

    // Byte-lane mask for a log2-bytes size; anything >= 8 bytes keeps the full word.
    function automatic logic [data_width_gp-1:0] size_mask(input logic [2:0] size);
        logic [data_width_gp-1:0] mask;
        case (size)
            3'd0:    mask = 64'h0000_0000_0000_00FF;
            3'd1:    mask = 64'h0000_0000_0000_FFFF;
            3'd2:    mask = 64'h0000_0000_FFFF_FFFF;
            default: mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/bp_fpga_host_io_exerciser_if.sv
// Purpose: one valid/ready message channel of the host I/O links.
// Latency: n/a (wires only).
// Backpressure: ready_and from the slave; on yumi-style channels the slave drives it as yumi.
// Ports: v, msg (master -> slave), ready_and (slave -> master).
interface bp_fpga_host_io_exerciser_if;
    import bp_fpga_host_exerciser_pkg::*;

    logic       v;
    bp_io_msg_s msg;
    logic       ready_and;

    modport master (output v, output msg, input  ready_and);
    modport slave  (input  v, input  msg, output ready_and);
endinterface

// File: rtl/bp_fpga_host_io_exerciser_debounce.sv
// Purpose: push-button synchroniser + debouncer producing a one-cycle rising-edge trigger.
// Latency: trigger fires 2 + debounce_cycles_p cycles after a clean rising edge on data_i.
// Backpressure: none; the trigger is a pulse and is dropped if nobody consumes it.
// Ports: clk_i, reset_i (async active-high), data_i (raw button), trigger_o (1-cycle pulse).
module bp_fpga_host_debounce #(
    parameter int debounce_cycles_p = 1000000
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic data_i,
    output logic trigger_o
);
    localparam int cnt_w_lp = $clog2(debounce_cycles_p + 1);
    localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(debounce_cycles_p - 1);

    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic                level_q, level_d;
    logic                trigger_q, trigger_d;
    logic [cnt_w_lp-1:0] cnt_q, cnt_d;

    // The counter only runs while the synchronised sample disagrees with the
    // accepted level, so any glitch back to the old level restarts the count.
    always_comb begin
        sync1_d   = data_i;
        sync2_d   = sync1_q;
        level_d   = level_q;
        cnt_d     = '0;
        trigger_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == cnt_last_lp) begin
                level_d   = sync2_q;
                trigger_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            level_q   <= 1'b0;
            trigger_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            level_q   <= level_d;
            trigger_q <= trigger_d;
            cnt_q     <= cnt_d;
        end
    end

    assign trigger_o = trigger_q;

endmodule

// File: rtl/bp_fpga_host_io_exerciser.sv
// Purpose: bring-up exerciser: button-triggered putchar store bursts toward the host, plus a
//          register-file responder for host commands.
// Latency: store v rises 1 cycle after trigger; responder answers 1 cycle after cmd yumi.
// Backpressure: stores stall on ready_and / outstanding limit; responder holds a 1-entry
//               buffer and stops yumi'ing host commands while it is full and not drained.
// Ports: clk_i, reset_i, send_i, burst_len_i, io_cmd_o/io_resp_i (host-bound link),
//        io_cmd_i/io_resp_o (host-originated link), busy_o, error_o, sent_count_o.
module bp_fpga_host_io_exerciser
    import bp_fpga_host_exerciser_pkg::*;
#(
    parameter int                        debounce_cycles_p = 1000000,
    parameter int                        max_burst_p       = 255,
    parameter int                        max_outstanding_p = 4,
    parameter int                        store_size_p      = 0,
    parameter int                        reg_els_p         = 8,
    parameter logic [paddr_width_gp-1:0] putchar_addr_p    = default_putchar_addr_gp,
    localparam int                       len_w_lp          = $clog2(max_burst_p + 1)
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         send_i,
    input  logic [len_w_lp-1:0]          burst_len_i,
    bp_fpga_host_io_exerciser_if.master  io_cmd_o,
    bp_fpga_host_io_exerciser_if.slave   io_resp_i,
    bp_fpga_host_io_exerciser_if.slave   io_cmd_i,
    bp_fpga_host_io_exerciser_if.master  io_resp_o,
    output logic                         busy_o,
    output logic                         error_o,
    output logic [15:0]                  sent_count_o
);
    localparam int out_w_lp      = $clog2(max_outstanding_p + 1);
    localparam int store_bits_lp = 8 << store_size_p;
    localparam int reg_idx_w_lp  = $clog2(reg_els_p);
    localparam logic [out_w_lp-1:0] out_max_lp = out_w_lp'(max_outstanding_p);

    // ---------------- debounce ----------------
    logic trigger;

    bp_fpga_host_debounce #(.debounce_cycles_p(debounce_cycles_p)) debounce (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .data_i    (send_i),
        .trigger_o (trigger)
    );

    // ---------------- generator FSM ----------------
    bp_fpga_host_exerciser_state_e state_q, state_d;
    logic [len_w_lp-1:0]      remaining_q, remaining_d;
    logic [store_bits_lp-1:0] data_q, data_d;
    logic [15:0]              sent_q, sent_d;
    logic [out_w_lp-1:0]      outstanding_q, outstanding_d;
    logic                     error_q, error_d;

    logic cmd_v, busy, cmd_accept, resp_yumi, bad_cmd;

    // Yumis are gated by reset so every output reads 0 while reset is held.
    assign cmd_accept = cmd_v & io_cmd_o.ready_and;
    assign resp_yumi  = io_resp_i.v & ~reset_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= e_ready;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            e_ready: if (trigger && (burst_len_i != '0)) state_d = e_send;
            e_send:  if (cmd_accept && (remaining_q == len_w_lp'(1))) state_d = e_drain;
            e_drain: if (outstanding_q == '0) state_d = e_ready;
            default: state_d = e_ready;
        endcase
    end

    always_comb begin
        cmd_v = (state_q == e_send) && (outstanding_q < out_max_lp);
        busy  = (state_q != e_ready);
    end

    always_comb begin
        remaining_d   = remaining_q;
        data_d        = data_q;
        sent_d        = sent_q;
        outstanding_d = outstanding_q;
        error_d       = error_q | bad_cmd;
        if ((state_q == e_ready) && trigger && (burst_len_i != '0)) remaining_d = burst_len_i;
        if (cmd_accept) begin
            data_d      = data_q + 1'b1;
            remaining_d = remaining_q - 1'b1;
            sent_d      = sent_q + 16'd1;
        end
        // A response with nothing outstanding is unsolicited: flag it, keep the counter at 0.
        unique case ({cmd_accept, resp_yumi})
            2'b10: outstanding_d = outstanding_q + 1'b1;
            2'b01: begin
                if (outstanding_q == '0) error_d = 1'b1;
                else                     outstanding_d = outstanding_q - 1'b1;
            end
            2'b11: if (outstanding_q == '0) error_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            remaining_q   <= '0;
            data_q        <= '0;
            sent_q        <= '0;
            outstanding_q <= '0;
            error_q       <= 1'b0;
        end else begin
            remaining_q   <= remaining_d;
            data_q        <= data_d;
            sent_q        <= sent_d;
            outstanding_q <= outstanding_d;
            error_q       <= error_d;
        end
    end

    // Command is forced to zero while idle so the link is quiet outside a burst.
    always_comb begin
        io_cmd_o.v   = cmd_v;
        io_cmd_o.msg = '0;
        if (cmd_v) begin
            io_cmd_o.msg.hdr.msg_type = msg_uc_wr_gp;
            io_cmd_o.msg.hdr.subop    = subop_store_gp;
            io_cmd_o.msg.hdr.addr     = putchar_addr_p;
            io_cmd_o.msg.hdr.size     = 3'(store_size_p);
            io_cmd_o.msg.data         = {(data_width_gp / store_bits_lp){data_q}};
        end
    end

    assign io_resp_i.ready_and = resp_yumi;
    assign busy_o              = busy;
    assign error_o             = error_q;
    assign sent_count_o        = sent_q;

    // ---------------- responder ----------------
    logic                     buf_v_q, buf_v_d;
    bp_io_msg_s               buf_msg_q, buf_msg_d;
    logic [data_width_gp-1:0] reg_q [reg_els_p];
    logic [data_width_gp-1:0] reg_d [reg_els_p];
    logic                     cmd_yumi;
    logic [reg_idx_w_lp-1:0]  reg_idx;
    logic [data_width_gp-1:0] mask;

    assign cmd_yumi = io_cmd_i.v & (~buf_v_q | io_resp_o.ready_and) & ~reset_i;
    assign reg_idx  = io_cmd_i.msg.hdr.addr[3 +: reg_idx_w_lp];
    assign mask     = size_mask(io_cmd_i.msg.hdr.size);

    always_comb begin
        buf_v_d   = buf_v_q;
        buf_msg_d = buf_msg_q;
        reg_d     = reg_q;
        bad_cmd   = 1'b0;
        if (buf_v_q && io_resp_o.ready_and) buf_v_d = 1'b0;
        if (cmd_yumi) begin
            buf_v_d        = 1'b1;
            buf_msg_d.hdr  = io_cmd_i.msg.hdr;
            buf_msg_d.data = '0;
            case (io_cmd_i.msg.hdr.msg_type)
                msg_uc_rd_gp: buf_msg_d.data = reg_q[reg_idx] & mask;
                msg_uc_wr_gp: reg_d[reg_idx] = io_cmd_i.msg.data & mask;
                default:      bad_cmd        = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            buf_v_q   <= 1'b0;
            buf_msg_q <= '0;
            for (int i = 0; i < reg_els_p; i++) reg_q[i] <= '0;
        end else begin
            buf_v_q   <= buf_v_d;
            buf_msg_q <= buf_msg_d;
            for (int i = 0; i < reg_els_p; i++) reg_q[i] <= reg_d[i];
        end
    end

    assign io_cmd_i.ready_and = cmd_yumi;
    assign io_resp_o.v        = buf_v_q;
    assign io_resp_o.msg      = buf_msg_q;

endmodule

// File: tb/tb_bp_fpga_host_io_exerciser.sv
module tb_bp_fpga_host_io_exerciser;
    import bp_fpga_host_exerciser_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       send_i = 1'b0;
    logic [7:0] burst_len = 8'd0;
    logic       busy, err;
    logic [15:0] sent;

    bp_fpga_host_io_exerciser_if cmd_o_if ();
    bp_fpga_host_io_exerciser_if resp_i_if ();
    bp_fpga_host_io_exerciser_if cmd_i_if ();
    bp_fpga_host_io_exerciser_if resp_o_if ();

    bp_fpga_host_io_exerciser #(
        .debounce_cycles_p (4),
        .max_burst_p       (255),
        .max_outstanding_p (2),
        .store_size_p      (0),
        .reg_els_p         (8),
        .putchar_addr_p    (40'h00_0010_1000)
    ) dut (
        .clk_i        (clk),
        .reset_i      (rst),
        .send_i       (send_i),
        .burst_len_i  (burst_len),
        .io_cmd_o     (cmd_o_if),
        .io_resp_i    (resp_i_if),
        .io_cmd_i     (cmd_i_if),
        .io_resp_o    (resp_o_if),
        .busy_o       (busy),
        .error_o      (err),
        .sent_count_o (sent)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- host model ----------------
    // Drives cmd ready and response valid at negedge+1, records accepts at negedge+2.
    logic host_rdy = 1'b0;
    logic auto_resp = 1'b0;
    logic force_resp = 1'b0;
    int   cyc = 0;
    int   pend_q[$];
    bp_io_msg_s store_q[$];

    initial begin
        cmd_o_if.ready_and = 1'b0;
        resp_i_if.v        = 1'b0;
        resp_i_if.msg      = '0;
        forever begin
            @(negedge clk);
            cyc++;
            #1;
            cmd_o_if.ready_and = host_rdy;
            resp_i_if.v = force_resp ||
                          (auto_resp && (pend_q.size() > 0) && (cyc >= pend_q[0] + 2));
            #1;
            if (resp_i_if.v && (pend_q.size() > 0)) void'(pend_q.pop_front());
            if (cmd_o_if.v && cmd_o_if.ready_and) begin
                pend_q.push_back(cyc);
                store_q.push_back(cmd_o_if.msg);
            end
        end
    end

    // Main-process inputs change at negedge+3, checks happen there too.
    task automatic tick();
        @(negedge clk);
        #3;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        host_rdy = 1'b0; auto_resp = 1'b0; force_resp = 1'b0; send_i = 1'b0;
        cmd_i_if.v = 1'b0; cmd_i_if.msg = '0; resp_o_if.ready_and = 1'b1;
        tick(); tick();
        pend_q.delete(); store_q.delete();
        rst = 1'b0;
        tick();
    endtask

    task automatic press(input int hi);
        send_i = 1'b1;
        repeat (hi) tick();
        send_i = 1'b0;
    endtask

    task automatic wait_busy(input logic lvl, input int budget, input string name);
        int n = 0;
        while ((busy !== lvl) && (n < budget)) begin tick(); n++; end
        chk(name, 64'(busy), 64'(lvl));
    endtask

    typedef struct {
        logic [3:0]  mt;
        logic [39:0] addr;
        logic [2:0]  size;
        logic [63:0] wdata;
        logic [63:0] exp_data;
    } vec_t;

    vec_t vecs [10];

    initial begin
        bp_io_hdr_s exp_hdr, hdr_a, hdr_b, saved_hdr;
        logic [63:0] saved_data;
        int first_busy, n, base;
        logic saw_busy;

        vecs[0] = '{msg_uc_wr_gp, 40'h18, 3'd3, 64'hDEAD_BEEF, 64'h0};
        vecs[1] = '{msg_uc_rd_gp, 40'h18, 3'd3, 64'hAAAA, 64'hDEAD_BEEF};
        vecs[2] = '{msg_uc_rd_gp, 40'h20, 3'd3, 64'hAAAA, 64'h0};
        vecs[3] = '{msg_uc_wr_gp, 40'h28, 3'd1, 64'h1122_3344_5566_7788, 64'h0};
        vecs[4] = '{msg_uc_rd_gp, 40'h28, 3'd3, 64'h0, 64'h7788};
        vecs[5] = '{msg_uc_rd_gp, 40'h18, 3'd0, 64'h0, 64'hEF};
        vecs[6] = '{msg_uc_wr_gp, 40'h00, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        vecs[7] = '{msg_uc_rd_gp, 40'h00, 3'd2, 64'h0, 64'hFFFF_FFFF};
        vecs[8] = '{msg_uc_wr_gp, 40'h58, 3'd0, 64'h1234_5655, 64'h0};
        vecs[9] = '{msg_uc_rd_gp, 40'h18, 3'd3, 64'h0, 64'h55};

        // ---- reset state ----
        do_reset();
        chk("rst_busy", 64'(busy), 0);
        chk("rst_error", 64'(err), 0);
        chk("rst_sent", 64'(sent), 0);
        chk("rst_cmd_v", 64'(cmd_o_if.v), 0);
        chk("rst_resp_v", 64'(resp_o_if.v), 0);

        // ---- short pulse and zero-length trigger are ignored ----
        saw_busy = 1'b0;
        burst_len = 8'd5;
        press(3);
        for (int i = 0; i < 12; i++) begin tick(); saw_busy |= busy; end
        chk("short_pulse_no_trigger", 64'(saw_busy), 0);
        burst_len = 8'd0;
        press(6);
        for (int i = 0; i < 12; i++) begin tick(); saw_busy |= busy; end
        chk("zero_len_ignored", 64'(saw_busy), 0);

        // ---- 5-store burst, 2-cycle response delay ----
        burst_len = 8'd5; host_rdy = 1'b1; auto_resp = 1'b1;
        first_busy = -1; n = 0;
        send_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(); n++;
            if (busy && first_busy < 0) first_busy = n;
        end
        send_i = 1'b0;
        while (first_busy < 0 && n < 40) begin
            tick(); n++;
            if (busy) first_busy = n;
        end
        chk("trigger_seen", 64'(first_busy > 0), 1);
        chk("trigger_latency_min", 64'(first_busy >= 6), 1);
        n = 0;
        while (busy && n < 100) begin tick(); n++; end
        chk("burst_done", 64'(busy), 0);
        chk("busy_fall_after_last_resp", 64'(pend_q.size()), 0);
        chk("burst_store_cnt", 64'(store_q.size()), 5);
        chk("burst_sent_count", 64'(sent), 5);
        exp_hdr = '{msg_uc_wr_gp, subop_store_gp, 40'h00_0010_1000, 3'd0};
        for (int i = 0; i < 5 && i < store_q.size(); i++) begin
            logic [7:0] b;
            b = 8'(i);
            chk($sformatf("store%0d_hdr", i), 64'(store_q[i].hdr), 64'(exp_hdr));
            chk($sformatf("store%0d_data", i), store_q[i].data, {8{b}});
        end
        chk("burst_no_error", 64'(err), 0);
        saw_busy = 1'b0;
        for (int i = 0; i < 20; i++) begin tick(); saw_busy |= busy; end
        chk("single_trigger", 64'(saw_busy), 0);

        // ---- outstanding limit with responses withheld ----
        auto_resp = 1'b0; base = store_q.size();
        press(6);
        wait_busy(1'b1, 20, "withhold_busy");
        repeat (8) tick();
        chk("withhold_accepts", 64'(store_q.size() - base), 2);
        chk("withhold_cmd_v_low", 64'(cmd_o_if.v), 0);
        force_resp = 1'b1;
        tick();
        force_resp = 1'b0;
        repeat (3) tick();
        chk("release_one_accepts", 64'(store_q.size() - base), 3);
        auto_resp = 1'b1;
        wait_busy(1'b0, 100, "withhold_done");
        chk("withhold_sent_count", 64'(sent), 10);
        chk("withhold_no_error", 64'(err), 0);
        if (store_q.size() == 10) chk("store9_data", store_q[9].data, {8{8'h09}});
        else chk("store_total", 64'(store_q.size()), 10);

        // ---- responder vector table ----
        resp_o_if.ready_and = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cmd_i_if.msg.hdr  = '{vecs[i].mt, 4'd0, vecs[i].addr, vecs[i].size};
            cmd_i_if.msg.data = vecs[i].wdata;
            cmd_i_if.v = 1'b1;
            #1;
            chk($sformatf("vec%0d_yumi", i), 64'(cmd_i_if.ready_and), 1);
            tick();
            cmd_i_if.v = 1'b0;
            chk($sformatf("vec%0d_resp_v", i), 64'(resp_o_if.v), 1);
            chk($sformatf("vec%0d_hdr", i), 64'(resp_o_if.msg.hdr), 64'(cmd_i_if.msg.hdr));
            chk($sformatf("vec%0d_data", i), resp_o_if.msg.data, vecs[i].exp_data);
        end
        tick();
        chk("resp_drained", 64'(resp_o_if.v), 0);

        // ---- response backpressure ----
        resp_o_if.ready_and = 1'b0;
        hdr_a = '{msg_uc_rd_gp, 4'd0, 40'h18, 3'd3};
        hdr_b = '{msg_uc_rd_gp, 4'd0, 40'h20, 3'd3};
        cmd_i_if.msg = '{hdr_a, 64'h0};
        cmd_i_if.v = 1'b1;
        #1;
        chk("bp_a_yumi", 64'(cmd_i_if.ready_and), 1);
        tick();
        cmd_i_if.msg = '{hdr_b, 64'h0};
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp_b_held%0d", i), 64'(cmd_i_if.ready_and), 0);
            chk($sformatf("bp_hdr_stable%0d", i), 64'(resp_o_if.msg.hdr), 64'(hdr_a));
            chk($sformatf("bp_data_stable%0d", i), resp_o_if.msg.data, 64'h55);
            tick();
        end
        resp_o_if.ready_and = 1'b1;
        #1;
        chk("bp_b_yumi", 64'(cmd_i_if.ready_and), 1);
        tick();
        cmd_i_if.v = 1'b0;
        chk("bp_b_resp_v", 64'(resp_o_if.v), 1);
        chk("bp_b_hdr", 64'(resp_o_if.msg.hdr), 64'(hdr_b));
        chk("bp_b_data", resp_o_if.msg.data, 64'h0);
        tick();

        // ---- unsolicited response ----
        chk("pre_unsolicited_error", 64'(err), 0);
        force_resp = 1'b1;
        tick();
        chk("unsolicited_yumi", 64'(resp_i_if.ready_and), 1);
        force_resp = 1'b0;
        tick();
        chk("unsolicited_error", 64'(err), 1);
        repeat (5) tick();
        chk("error_sticky", 64'(err), 1);

        // ---- unsupported command type ----
        do_reset();
        cmd_i_if.msg = '{'{4'd5, 4'd0, 40'h18, 3'd3}, 64'h1234};
        cmd_i_if.v = 1'b1;
        #1;
        chk("badcmd_yumi", 64'(cmd_i_if.ready_and), 1);
        tick();
        cmd_i_if.v = 1'b0;
        chk("badcmd_hdr_echo", 64'(resp_o_if.msg.hdr), 64'(cmd_i_if.msg.hdr));
        chk("badcmd_data", resp_o_if.msg.data, 64'h0);
        chk("badcmd_error", 64'(err), 1);

        // ---- reset mid-burst ----
        do_reset();
        burst_len = 8'd5; host_rdy = 1'b0;
        press(6);
        wait_busy(1'b1, 20, "midrst_busy");
        chk("midrst_cmd_v", 64'(cmd_o_if.v), 1);
        saved_hdr  = cmd_o_if.msg.hdr;
        saved_data = cmd_o_if.msg.data;
        tick();
        chk("cmd_hold_hdr", 64'(cmd_o_if.msg.hdr), 64'(saved_hdr));
        chk("cmd_hold_data", cmd_o_if.msg.data, saved_data);
        force_resp = 1'b1;
        tick(); tick();
        chk("midrst_pre_error", 64'(err), 1);
        cmd_i_if.msg = '{'{msg_uc_rd_gp, 4'd0, 40'h18, 3'd3}, 64'h0};
        cmd_i_if.v = 1'b1;
        rst = 1'b1;
        #1;
        chk("midrst_busy0", 64'(busy), 0);
        chk("midrst_error0", 64'(err), 0);
        chk("midrst_sent0", 64'(sent), 0);
        chk("midrst_cmd_v0", 64'(cmd_o_if.v), 0);
        chk("midrst_cmd_data0", cmd_o_if.msg.data, 0);
        chk("midrst_cmd_hdr0", 64'(cmd_o_if.msg.hdr), 0);
        chk("midrst_resp_yumi0", 64'(resp_i_if.ready_and), 0);
        chk("midrst_cmd_yumi0", 64'(cmd_i_if.ready_and), 0);
        chk("midrst_resp_v0", 64'(resp_o_if.v), 0);
        chk("midrst_resp_msg0", 64'(resp_o_if.msg), 0);
        force_resp = 1'b0;
        cmd_i_if.v = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("postrst_error", 64'(err), 0);
        force_resp = 1'b1;
        tick();
        force_resp = 1'b0;
        tick();
        chk("late_resp_error", 64'(err), 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
